// File: rtl/score_bcd_encoder_if.sv
// Handshake and result bundle for score_bcd_encoder.
// Build option LEADING_ZERO_BLANK_EN adds the blank vector.
interface score_bcd_encoder_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       bcd0;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic [3:0]       bcd3;
  logic             overflow;
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0]       blank;

  modport master (
    output start, bin,
    input  busy, done, bcd0, bcd1, bcd2, bcd3, overflow, blank
  );
  modport slave (
    input  start, bin,
    output busy, done, bcd0, bcd1, bcd2, bcd3, overflow, blank
  );
`else
  modport master (
    output start, bin,
    input  busy, done, bcd0, bcd1, bcd2, bcd3, overflow
  );
  modport slave (
    input  start, bin,
    output busy, done, bcd0, bcd1, bcd2, bcd3, overflow
  );
`endif
endinterface

// File: rtl/score_bcd_encoder.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Build option LEADING_ZERO_BLANK_EN adds registered leading-zero blanking.
module score_bcd_encoder #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic               clock,
  input  logic               reset,
  score_bcd_encoder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_scratch;
  logic [4*DIGITS-1:0] w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf_cap;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic [3:0]          r_bcd0;
  logic [3:0]          r_bcd1;
  logic [3:0]          r_bcd2;
  logic [3:0]          r_bcd3;
  logic                w_last;
  logic                w_bin_big;

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_bin_big = (17'(bus.bin) > 17'd9999);

  always_comb begin
    w_adj = r_scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] r_blank;
  logic [3:0] w_blank;

  // Digit i is blanked only when it and every higher digit are zero.
  always_comb begin
    w_blank    = '0;
    w_blank[3] = (r_scratch[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_scratch[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (r_scratch[7:4] == 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_blank <= '0;
    else if (r_state == FINISH)
      r_blank <= r_ovf_cap ? '0 : w_blank;
  end

  assign bus.blank = r_blank;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_cap  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd0     <= '0;
      r_bcd1     <= '0;
      r_bcd2     <= '0;
      r_bcd3     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= w_bin_big;
          end
        end
        SHIFT: begin
          // busy rises on the first shift edge, one edge after the accepted start.
          r_busy                <= 1'b1;
          {r_scratch, r_shift}  <= {w_adj, r_shift} << 1;
          r_cnt                 <= r_cnt + 1'b1;
        end
        FINISH: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_overflow <= r_ovf_cap;
          if (r_ovf_cap) begin
            r_bcd0 <= 4'd9;
            r_bcd1 <= 4'd9;
            r_bcd2 <= 4'd9;
            r_bcd3 <= 4'd9;
          end else begin
            r_bcd0 <= r_scratch[3:0];
            r_bcd1 <= r_scratch[7:4];
            r_bcd2 <= r_scratch[11:8];
            r_bcd3 <= r_scratch[15:12];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;
  assign bus.bcd0     = r_bcd0;
  assign bus.bcd1     = r_bcd1;
  assign bus.bcd2     = r_bcd2;
  assign bus.bcd3     = r_bcd3;
endmodule

// File: tb/tb_score_bcd_encoder.sv
// Scoreboard bench for score_bcd_encoder; define LEADING_ZERO_BLANK_EN to cover blanking.
module tb_score_bcd_encoder;
  localparam int W = 14;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  score_bcd_encoder_if #(.WIDTH(W)) bus ();
  score_bcd_encoder #(.WIDTH(W), .DIGITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] d3, d2, d1, d0;
    logic       ovf;
    logic [3:0] blank;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   done_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  always @(posedge clock) cyc++;

  function automatic res_t sample();
    res_t r;
    r.d3 = bus.bcd3; r.d2 = bus.bcd2; r.d1 = bus.bcd1; r.d0 = bus.bcd0;
    r.ovf = bus.overflow;
`ifdef LEADING_ZERO_BLANK_EN
    r.blank = bus.blank;
`else
    r.blank = '0;
`endif
    return r;
  endfunction

  function automatic res_t model(input int unsigned v);
    res_t r;
    if (v > 9999) begin
      r = '{4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 4'b0000};
    end else begin
      r.d3 = 4'(v / 1000); r.d2 = 4'((v / 100) % 10);
      r.d1 = 4'((v / 10) % 10); r.d0 = 4'(v % 10);
      r.ovf = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r.blank = {r.d3 == 0, (r.d3 == 0) && (r.d2 == 0),
                 (r.d3 == 0) && (r.d2 == 0) && (r.d1 == 0), 1'b0};
`else
      r.blank = '0;
`endif
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (bus.done) begin
      obs_q.push_back(sample());
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  task automatic pulse_start(input int unsigned v);
    @(negedge clock);
    bus.bin   = W'(v);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic convert(input int unsigned v, output int lat, output int bcyc);
    exp_q.push_back(model(v));
    pulse_start(v);
    lat  = -1;
    bcyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) bcyc++;
    end
    if (lat < 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout bin=%0d: done not seen in 40 cycles, required a done pulse", v);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.bin = '0;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({bus.busy, bus.done, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, bus.overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b bcd=%h%h%h%h ovf=%b required all 0",
               bus.busy, bus.done, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, bus.overflow);
    end
`ifdef LEADING_ZERO_BLANK_EN
    n_vec++;
    if (bus.blank !== 4'b0000) begin
      n_err++; $display("FAIL reset_blank got %b required 0000", bus.blank);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bcyc;
    res_t got, ex;
    convert(0, lat, bcyc);
    n_vec++;
    if (lat !== 15) begin n_err++; $display("FAIL latency got %0d required 15", lat); end
    n_vec++;
    if (bcyc !== 14) begin n_err++; $display("FAIL busy_cycles got %0d required 14", bcyc); end
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    ex  = exp_q.pop_front();
    n_vec++;
    if (got !== ex) begin n_err++; $display("FAIL conv_0 got %h required %h", got, ex); end
  endtask

  task automatic test_values();
    int unsigned vals[4] = '{1234, 9999, 10000, 16383};
    int lat, bcyc;
    res_t got, ex;
    foreach (vals[k]) begin
      convert(vals[k], lat, bcyc);
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      ex  = exp_q.pop_front();
      n_vec++;
      if (got !== ex) begin
        n_err++; $display("FAIL conv_%0d got %h required %h", vals[k], got, ex);
      end
    end
  endtask

  task automatic test_ignore_start();
    int c0 = done_cnt;
    bit seen = 0;
    res_t got, ex;
    exp_q.push_back(model(42));
    pulse_start(42);
    repeat (4) @(negedge clock);
    bus.bin = W'(777); bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) begin seen = 1; break; end
    end
    repeat (25) @(negedge clock);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL ignore_done got no done required one"); end
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    ex  = exp_q.pop_front();
    n_vec++;
    if (got !== ex) begin n_err++; $display("FAIL ignore_result got %h required %h", got, ex); end
    n_vec++;
    if (done_cnt - c0 !== 1) begin
      n_err++; $display("FAIL ignore_pulses got %0d required 1", done_cnt - c0);
    end
  endtask

  task automatic test_reset_abort();
    int c0 = done_cnt;
    int lat, bcyc;
    res_t got, ex;
    pulse_start(500);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_vec++;
    if ({bus.busy, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, bus.overflow} !== '0) begin
      n_err++;
      $display("FAIL abort_state got busy=%b bcd=%h%h%h%h ovf=%b required all 0",
               bus.busy, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, bus.overflow);
    end
    repeat (25) @(negedge clock);
    n_vec++;
    if (done_cnt !== c0) begin n_err++; $display("FAIL abort_done got %0d pulses required 0", done_cnt - c0); end
    convert(500, lat, bcyc);
    got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    ex  = exp_q.pop_front();
    n_vec++;
    if (got !== ex) begin n_err++; $display("FAIL after_abort got %h required %h", got, ex); end
  endtask

  task automatic test_back_to_back();
    int c0 = done_cnt;
    int n0 = done_cyc.size();
    int bad = 0;
    bit first = 0;
    res_t one = model(1);
    res_t got;
    @(negedge clock);
    bus.bin = W'(1); bus.start = 1'b1;
    for (int i = 0; i < 100 && done_cnt < c0 + 4; i++) begin
      @(negedge clock);
      #1;
      if (done_cnt > c0) first = 1;
      if (first && sample() !== one) bad++;
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clock);
    n_vec++;
    if (done_cyc.size() < n0 + 4) begin
      n_err++; $display("FAIL b2b_count got %0d pulses required at least 4", done_cyc.size() - n0);
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_vec++;
        if (done_cyc[n0+k] - done_cyc[n0+k-1] !== 16) begin
          n_err++;
          $display("FAIL b2b_period got %0d required 16", done_cyc[n0+k] - done_cyc[n0+k-1]);
        end
      end
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL b2b_hold got %0d unstable cycles required 0", bad); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_vec++;
      if (got !== one) begin n_err++; $display("FAIL b2b_result got %h required %h", got, one); end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    int unsigned vals[3] = '{7, 1005, 0};
    logic [3:0]  want[3] = '{4'b1110, 4'b0000, 4'b1110};
    int lat, bcyc;
    res_t got, ex;
    foreach (vals[k]) begin
      convert(vals[k], lat, bcyc);
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      ex  = exp_q.pop_front();
      n_vec++;
      if (got !== ex) begin n_err++; $display("FAIL blank_conv_%0d got %h required %h", vals[k], got, ex); end
      n_vec++;
      if (bus.blank !== want[k]) begin
        n_err++; $display("FAIL blank_%0d got %b required %b", vals[k], bus.blank, want[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running required completion");
    $fatal(1);
  end
endmodule
